countdown_arbiter: RTL and testbench
====================================

# countdown_arbiter

Round-robin scheduler that shares a single loadable 4-bit down counter between several requesters. Each requester asks for a delay of N clock cycles; the arbiter grants the counter to one requester, loads that requester's value, counts down to zero, and pulses `done` back to the winner. It sits between the down-counter datapath and the control blocks that need timed waits, so only one counter instance is required for all of them.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `CNT_W`, 4: counter width
- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-high reset
- `req` input N_REQ: per-requester request level
- `load_val` input N_REQ*CNT_W: packed delay values; requester i uses bits [i*CNT_W +: CNT_W]
- `gnt` output N_REQ: one-hot grant, held for the whole job
- `done` output N_REQ: one-cycle completion pulse to the granted requester
- `busy` output 1: counter owned (state COUNT or DONE)
- `count` output CNT_W: current counter value

## Operation
- States:
  - IDLE: no owner.
  - COUNT: decrementing.
  - DONE: completion cycle.
- IDLE, `req`==0: stay in IDLE; `gnt`=0.
- IDLE, any `req` set:
  - The winner is the first set bit searching upward from `ptr`, wrapping at N_REQ.
  - On the clock edge: `gnt`<=onehot(winner), `count`<=`load_val`[winner], state<=COUNT.
- COUNT, `count`!=0: `count`<=`count`-1.
- COUNT, `count`==0: state<=DONE. `count` holds at 0 and never wraps to all-ones.
- DONE:
  - `done`[winner]=1 for exactly this cycle; `gnt` is still asserted.
  - On the next edge: `gnt`<=0, `ptr`<=(winner+1) mod N_REQ, state<=IDLE.
- A requester holds `req` until it sees `done`. It drops `req` the cycle after `done`, otherwise it is re-arbitrated. Because `ptr` has advanced, it now has the lowest priority.
- `load_val` is sampled only on the grant edge. Later changes are ignored.
- Requests arriving during COUNT or DONE wait. Arbitration happens only in IDLE, so there is one idle cycle between jobs.
- Reset values: state IDLE, `gnt`=0, `done`=0, `busy`=0, `ptr`=0, `count`=all ones (4'hF at default width). Reset in any state returns to these values on the next edge; no `done` is issued for the aborted job.

## Timing
- For load value L, `gnt` is high for L+2 cycles: L+1 cycles in COUNT (values L..0) plus 1 cycle in DONE.
- `done` is asserted in the last of those cycles.
- Grant latency: `gnt` rises on the first edge at which IDLE samples `req`=1.
- L=0: COUNT shows 0 for one cycle, then DONE, so `gnt` is high for 2 cycles.
- L=all ones: `gnt` is high for 2^CNT_W+1 cycles.
- `busy` = (state!=IDLE), registered in step with the state.

## Configuration
- `COUNTDOWN_ARB_ABORT_EN` defined:
  - If the owner deasserts `req` during COUNT, the next edge goes straight to IDLE: `gnt`<=0, no `done`, `ptr` advances past the owner, `count` holds its current value.
  - Deasserting `req` during DONE has no effect; `done` is still pulsed.
- Not defined: `req` is ignored once granted, and every job runs to `done`.

## Structure
- Package `countdown_arb_pkg`:
  - state enum (IDLE, COUNT, DONE)
  - default `CNT_W`, `N_REQ` constants
  - count reset constant (all ones)
- Sub-module `rr_picker`: combinational round-robin search. Inputs `req` and `ptr`; outputs one-hot `pick`, binary `pick_idx` and `any`.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `req`=4'b1111. Expect `gnt`=0, `done`=0, `busy`=0, `count`=4'hF; after release, requester 0 wins first.
- Single job: `req`=4'b0100, `load_val`[2]=3. Expect `gnt`=4'b0100 for 5 cycles, `count` 3,2,1,0,0, and `done`=4'b0100 in the 5th cycle only.
- Round-robin: all four `req` held continuously, each `load_val`=1. Expect grant order 0,1,2,3,0, with one IDLE cycle between jobs.
- Boundaries:
  - `load_val`=0 gives `gnt` for 2 cycles.
  - `load_val`=4'hF gives `gnt` for 17 cycles, and `count` never wraps below 0.
- Mid-job reset: assert `reset` while `count`=5. Next cycle: state IDLE, `count`=4'hF, no `done` pulse.
- `COUNTDOWN_ARB_ABORT_EN`: owner drops `req` at `count`=2. Next cycle `gnt`=0, no `done`, and the next requester is granted after the following edge. Without the macro, the same stimulus still produces `done` on schedule.

Source files
------------

// File: rtl/countdown_arbiter_pkg.sv
// Shared types and defaults for the round-robin countdown arbiter.
package countdown_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 4;

  // The counter resets to all ones at the default width.
  localparam logic [CNT_W_DEF-1:0] CNT_RST = '1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

endpackage

// File: rtl/countdown_arbiter_if.sv
// Request/grant bundle between requesters (master) and the countdown arbiter (slave).
interface countdown_arbiter_if
  import countdown_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] load_val;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [CNT_W-1:0]       count;

  modport master (output req, output load_val, input gnt, input done, input busy, input count);
  modport slave  (input req, input load_val, output gnt, output done, output busy, output count);

endinterface

// File: rtl/countdown_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, wrapping at N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any
);

  localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

  logic [IW:0] sum;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // One extra bit so ptr+k can be folded back into range without overflow.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      if (!any && req[sum[IW-1:0]]) begin
        any                 = 1'b1;
        pick_idx            = sum[IW-1:0];
        pick[sum[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_arbiter.sv
// Shares one loadable down counter among N_REQ requesters in round-robin order.
// Optional COUNTDOWN_ARB_ABORT_EN: owner dropping req during COUNT aborts the job.
module countdown_arbiter
  import countdown_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                clk,
  input logic                reset,
  countdown_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [IW-1:0]    own_reg, own_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [CNT_W-1:0] load_arr [N_REQ];
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             any;
  logic [IW-1:0]    own_inc;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_load
      assign load_arr[gi] = bus.load_val[gi*CNT_W +: CNT_W];
    end
  endgenerate

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req      (bus.req),
    .ptr      (ptr_reg),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  assign own_inc = (own_reg == IW'(N_REQ-1)) ? '0 : own_reg + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ptr_reg   <= '0;
      own_reg   <= '0;
      count_reg <= '1;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ptr_reg   <= ptr_next;
      own_reg   <= own_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ptr_next   = ptr_reg;
    own_next   = own_reg;
    count_next = count_reg;
    unique case (state_reg)
      IDLE: begin
        if (any) begin
          gnt_next   = pick;
          own_next   = pick_idx;
          count_next = load_arr[pick_idx];
          state_next = COUNT;
        end
      end
      COUNT: begin
`ifdef COUNTDOWN_ARB_ABORT_EN
        if (!bus.req[own_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = own_inc;
        end else
`endif
        // Count saturates at zero; the zero cycle is shown once before DONE.
        if (count_reg != '0) count_next = count_reg - CNT_W'(1);
        else state_next = DONE;
      end
      DONE: begin
        gnt_next   = '0;
        ptr_next   = own_inc;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.gnt   = gnt_reg;
  assign bus.done  = (state_reg == DONE) ? gnt_reg : '0;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.count = count_reg;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed self-checking bench for countdown_arbiter (4 requesters, 4-bit counter).
module tb_countdown_arbiter;
  import countdown_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  countdown_arbiter_if #(.N_REQ(4), .CNT_W(4)) bus ();

  countdown_arbiter #(.N_REQ(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs one job for requester mask with load value lv; checks length, done timing and count sequence.
  task automatic run_job(input string tag, input logic [3:0] mask, input logic [3:0] lv, input int exp_len);
    int len = 0;
    int ndone = 0;
    int done_at = 0;
    int bad = 0;
    logic [3:0] exp_cnt;
    bus.load_val = {4{lv}};
    bus.req      = mask;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.gnt != 4'b0) begin
        len++;
        exp_cnt = ((len - 1) <= int'(lv)) ? lv - 4'(len - 1) : 4'd0;
        if (bus.count !== exp_cnt || bus.gnt !== mask) bad++;
        if (bus.done != 4'b0) begin
          ndone++;
          done_at = len;
          if (bus.done !== mask) bad++;
          bus.req = '0;
        end
      end else if (len > 0) begin
        break;
      end
    end
    bus.req = '0;
    $display("job %s: mask=%b load=%0d gnt_cycles=%0d done_at=%0d", tag, mask, lv, len, done_at);
    chk({tag, "_len"}, len, exp_len);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_done_at"}, done_at, exp_len);
    chk({tag, "_seq"}, bad, 0);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] cnt3 [5];
    cnt3[0] = 4'd3; cnt3[1] = 4'd2; cnt3[2] = 4'd1; cnt3[3] = 4'd0; cnt3[4] = 4'd0;

    // Reset held with all requests pending
    reset        = 1'b1;
    bus.req      = 4'b1111;
    bus.load_val = {4{4'd1}};
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 4'b0);
    chk("rst_done", bus.done, 4'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_count", bus.count, CNT_RST);
    reset = 1'b0;
    tick();
    chk("rst_first_winner", bus.gnt, 4'b0001);
    $display("reset: first grant %b", bus.gnt);
    do_reset();

    // Single job on requester 2, load 3
    bus.load_val = 16'h0300;
    bus.req      = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("single_gnt%0d", c), bus.gnt, 4'b0100);
      chk($sformatf("single_cnt%0d", c), bus.count, cnt3[c]);
      chk($sformatf("single_done%0d", c), bus.done, (c == 4) ? 4'b0100 : 4'b0000);
    end
    bus.req = '0;
    tick();
    chk("single_release", bus.gnt, 4'b0);
    chk("single_busy_off", bus.busy, 1'b0);
    $display("single job: requester 2 load 3 complete");

    // Round-robin with all requests held, load 1: 3 grant cycles plus 1 idle per job
    do_reset();
    bus.load_val = {4{4'd1}};
    bus.req      = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      tick();
      exp_g = ((c % 4) < 3) ? (4'b0001 << ((c / 4) % 4)) : 4'b0000;
      chk($sformatf("rr_gnt%0d", c), bus.gnt, exp_g);
      chk($sformatf("rr_done%0d", c), bus.done, ((c % 4) == 2) ? exp_g : 4'b0000);
      if ((c % 4) == 2) $display("rr: job %0d done gnt=%b", c / 4, bus.gnt);
    end
    bus.req = '0;

    // Boundaries: load 0 and load all ones
    do_reset();
    run_job("l0", 4'b0001, 4'd0, 2);
    do_reset();
    run_job("lf", 4'b1000, 4'hF, 17);

    // Mid-job reset at count 5
    do_reset();
    bus.load_val = {4{4'd7}};
    bus.req      = 4'b0001;
    tick();
    tick();
    tick();
    chk("mid_count5", bus.count, 4'd5);
    reset = 1'b1;
    tick();
    chk("mid_gnt", bus.gnt, 4'b0);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_count", bus.count, 4'hF);
    chk("mid_done", bus.done, 4'b0);
    reset   = 1'b0;
    bus.req = '0;
    tick();
    chk("mid_no_done", bus.done, 4'b0);
    $display("mid-job reset: aborted at count 5");

    // Owner drops req at count 2
    do_reset();
    bus.load_val = {4{4'd4}};
    bus.req      = 4'b0011;
    tick();
    chk("ab_gnt0", bus.gnt, 4'b0001);
    tick();
    tick();
    chk("ab_count2", bus.count, 4'd2);
    bus.req = 4'b0010;
    tick();
`ifdef COUNTDOWN_ARB_ABORT_EN
    chk("ab_gnt_off", bus.gnt, 4'b0);
    chk("ab_no_done", bus.done, 4'b0);
    chk("ab_count_hold", bus.count, 4'd2);
    tick();
    chk("ab_next_gnt", bus.gnt, 4'b0010);
    $display("abort: owner 0 dropped, requester 1 granted");
`else
    chk("ab_cnt1", bus.count, 4'd1);
    tick();
    chk("ab_cnt0", bus.count, 4'd0);
    chk("ab_no_early_done", bus.done, 4'b0);
    tick();
    chk("ab_done", bus.done, 4'b0001);
    $display("no abort: owner 0 still done on schedule");
`endif
    bus.req = '0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
